sdram_cmd_arbiter: RTL and testbench
====================================

// Module: sdram_cmd_arbiter
// PURPOSE
//  Arbitrates the single SDRAM command/address bus between the init, auto-refresh, write and read engines.
//  Sits in the SDRAM controller top, between the per-function engines and the SDRAM_* pins.
//  Grants one owner at a time, muxes its command, address and bank onto registered outputs, and
//  flags a pending refresh so the active burst engine can close early.
// PARAMETERS
//  ADDR_W      12     SDRAM A_ADDR width
//  BA_W        2      SDRAM bank address width
//  TIMEOUT     1023   max cycles an owner may hold the bus without its End pulse
// PORTS
//  Sys_clk      in   1      system clock; all logic on rising edge
//  Rst          in   1      asynchronous, active-high reset
//  Init_done    in   1      init engine finished; level
//  Init_cmd     in   4      {CS_N,RAS_N,CAS_N,WE_N} from init engine
//  Init_addr    in   ADDR_W init engine address
//  Init_ba      in   BA_W   init engine bank
//  Ref_req      in   1      refresh timer request; level, held until granted
//  Ref_end      in   1      refresh engine done; 1-cycle pulse
//  Wr_req       in   1      write engine request (write FIFO reached burst threshold); level
//  Wr_end       in   1      write burst done; 1-cycle pulse
//  Rd_req       in   1      read engine request; level
//  Rd_end       in   1      read burst done; 1-cycle pulse
//  Ref_cmd/Wr_cmd/Rd_cmd     in  4       per-engine command
//  Ref_addr/Wr_addr/Rd_addr  in  ADDR_W  per-engine address
//  Ref_ba/Wr_ba/Rd_ba        in  BA_W    per-engine bank
//  Ref_en       out  1      refresh grant; 1-cycle pulse
//  Wr_en        out  1      write grant; 1-cycle pulse
//  Rd_en        out  1      read grant; 1-cycle pulse
//  Ref_pending  out  1      Ref_req seen while WRITE/READ active
//  Arb_err      out  1      1-cycle pulse on owner timeout
//  SDRAM_CMD    out  4      registered {CS_N,RAS_N,CAS_N,WE_N}
//  SDRAM_A_ADDR out  ADDR_W registered address
//  SDRAM_BANK_ADDR out BA_W registered bank
// BEHAVIOUR
//  Reset: state INIT, SDRAM_CMD=4'b0111 (NOP), addr=0, bank=0, all *_en=0, Ref_pending=0, Arb_err=0, last_wr=0, timer=0.
//  States: INIT, IDLE, REFRESH, WRITE, READ.
//  - INIT: mux = init engine. -> IDLE when Init_done=1.
//  - IDLE: mux forces NOP. Evaluated every cycle; priority is Ref_req first, then Wr/Rd.
//    If Wr_req and Rd_req are both set: READ when last_wr=1, else WRITE (alternation).
//    Entering REFRESH/WRITE/READ pulses the matching *_en in that same transition cycle. last_wr is updated on each Wr/Rd grant.
//  - REFRESH/WRITE/READ: mux = owner engine. -> IDLE on the owner's *_end. End pulses from non-owners are ignored.
//  Minimum one IDLE (NOP) cycle between owners, including when End and a new request coincide.
//  Output latency: SDRAM_* = registered mux; 1 cycle from engine input to pin.
//  Ref_pending = Ref_req & (state==WRITE | state==READ); registered. The engine ends its burst at the next legal point.
//  Timeout: 10-bit timer clears on every grant and counts while in REFRESH/WRITE/READ.
//    At timer==TIMEOUT: -> IDLE, Arb_err pulse, SDRAM_CMD=NOP that cycle. The timer saturates and does not wrap.
//  Init_done low outside INIT: -> INIT at once (mux=init); any grant in progress is abandoned.
//  Async Rst mid-burst: outputs go to reset values immediately; no End is expected afterwards.
// STRUCTURE
//  Shared package sdram_pkg: CMD_NOP/ACT/RD/WR/PRE/REF/MRS 4-bit constants, state enum, ADDR_W/BA_W defaults.
//  No sub-module; FSM, timer and output mux live in one file.
// TESTING
//  1 Rst=1 held, then released with Init_done=0 -> SDRAM_CMD=4'b0111; init cmd 4'b0010 appears on the pin 1 cycle later.
//  2 Init_done=1, then Wr_req=1 -> Wr_en pulses once; Wr_cmd 4'b0100 / Wr_addr 12'h0A5 appear on the pins +1 cycle;
//    Wr_end -> 1 NOP cycle.
//  3 Ref_req, Wr_req and Rd_req rise in the same IDLE cycle -> Ref_en first. After Ref_end: Wr_en, then Rd_en, then alternation.
//  4 Ref_req raised during WRITE -> Ref_pending=1 next cycle; after Wr_end, Ref_en follows an IDLE cycle even though Rd_req=1.
//  5 WRITE granted, Wr_end withheld -> Arb_err pulses at timer==1023; state returns to IDLE; SDRAM_CMD=NOP.
//  6 Rst asserted mid-READ -> same-cycle NOP and all *_en=0; after release, INIT is re-entered.

Source files
------------

// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_pkg
//  Description : Shared SDRAM command encodings, arbiter state type and
//                default bus widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdram_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int BA_W_DEF   = 2;

    // {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_REFRESH = 3'd2,
        ST_WRITE   = 3'd3,
        ST_READ    = 3'd4
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/sdram_cmd_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_cmd_arbiter_if
//  Description : Engine-side requests/commands and SDRAM pin outputs of the
//                command-bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sdram_cmd_arbiter_if
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BA_W   = BA_W_DEF
);
    logic              Init_done;
    logic [3:0]        Init_cmd;
    logic [ADDR_W-1:0] Init_addr;
    logic [BA_W-1:0]   Init_ba;

    logic              Ref_req;
    logic              Ref_end;
    logic [3:0]        Ref_cmd;
    logic [ADDR_W-1:0] Ref_addr;
    logic [BA_W-1:0]   Ref_ba;

    logic              Wr_req;
    logic              Wr_end;
    logic [3:0]        Wr_cmd;
    logic [ADDR_W-1:0] Wr_addr;
    logic [BA_W-1:0]   Wr_ba;

    logic              Rd_req;
    logic              Rd_end;
    logic [3:0]        Rd_cmd;
    logic [ADDR_W-1:0] Rd_addr;
    logic [BA_W-1:0]   Rd_ba;

    logic              Ref_en;
    logic              Wr_en;
    logic              Rd_en;
    logic              Ref_pending;
    logic              Arb_err;
    logic [3:0]        SDRAM_CMD;
    logic [ADDR_W-1:0] SDRAM_A_ADDR;
    logic [BA_W-1:0]   SDRAM_BANK_ADDR;

    modport master (
        output Init_done, Init_cmd, Init_addr, Init_ba,
        output Ref_req, Ref_end, Ref_cmd, Ref_addr, Ref_ba,
        output Wr_req, Wr_end, Wr_cmd, Wr_addr, Wr_ba,
        output Rd_req, Rd_end, Rd_cmd, Rd_addr, Rd_ba,
        input  Ref_en, Wr_en, Rd_en, Ref_pending, Arb_err,
        input  SDRAM_CMD, SDRAM_A_ADDR, SDRAM_BANK_ADDR
    );

    modport slave (
        input  Init_done, Init_cmd, Init_addr, Init_ba,
        input  Ref_req, Ref_end, Ref_cmd, Ref_addr, Ref_ba,
        input  Wr_req, Wr_end, Wr_cmd, Wr_addr, Wr_ba,
        input  Rd_req, Rd_end, Rd_cmd, Rd_addr, Rd_ba,
        output Ref_en, Wr_en, Rd_en, Ref_pending, Arb_err,
        output SDRAM_CMD, SDRAM_A_ADDR, SDRAM_BANK_ADDR
    );

endinterface
`default_nettype wire

// File: rtl/sdram_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_cmd_arbiter
//  Description : Grants the SDRAM command bus to init/refresh/write/read
//                engines and drives the registered SDRAM command pins.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_cmd_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int BA_W    = BA_W_DEF,
    parameter int TIMEOUT = 1023
) (
    input  wire logic          Sys_clk,
    input  wire logic          Rst,
    sdram_cmd_arbiter_if.slave bus
);

    localparam logic [9:0] c_timeout = 10'(TIMEOUT);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic              r_last_wr;
    logic [9:0]        r_timer;

    logic              w_owner;
    logic              w_owner_end;
    logic              w_timeout;
    logic              w_grant;

    logic [3:0]        w_cmd;
    logic [ADDR_W-1:0] w_addr;
    logic [BA_W-1:0]   w_ba;

    logic              r_ref_en;
    logic              r_wr_en;
    logic              r_rd_en;
    logic              r_ref_pending;
    logic              r_arb_err;
    logic [3:0]        r_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [BA_W-1:0]   r_ba;

    assign w_owner = (r_state == ST_REFRESH) || (r_state == ST_WRITE) || (r_state == ST_READ);

    always_comb begin
        w_owner_end = 1'b0;
        case (r_state)
            ST_REFRESH: w_owner_end = bus.Ref_end;
            ST_WRITE:   w_owner_end = bus.Wr_end;
            ST_READ:    w_owner_end = bus.Rd_end;
            default:    w_owner_end = 1'b0;
        endcase
    end

    // A real End in the same cycle as the limit is a normal completion
    assign w_timeout = w_owner && (r_timer == c_timeout) && !w_owner_end;

    assign w_grant = (r_state == ST_IDLE) &&
                     ((w_next == ST_REFRESH) || (w_next == ST_WRITE) || (w_next == ST_READ));

    // ---------------- state register ----------------
    always_ff @(posedge Sys_clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT: begin
                if (bus.Init_done) w_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.Ref_req)                    w_next = ST_REFRESH;
                else if (bus.Wr_req && bus.Rd_req)  w_next = r_last_wr ? ST_READ : ST_WRITE;
                else if (bus.Wr_req)                w_next = ST_WRITE;
                else if (bus.Rd_req)                w_next = ST_READ;
            end
            default: begin
                if (w_owner_end || w_timeout) w_next = ST_IDLE;
            end
        endcase
        // Losing init status overrides everything, including a pending grant
        if ((r_state != ST_INIT) && !bus.Init_done) w_next = ST_INIT;
    end

    // ---------------- output mux ----------------
    always_comb begin
        w_cmd  = CMD_NOP;
        w_addr = '0;
        w_ba   = '0;
        case (r_state)
            ST_INIT: begin
                w_cmd  = bus.Init_cmd;
                w_addr = bus.Init_addr;
                w_ba   = bus.Init_ba;
            end
            ST_REFRESH: begin
                w_cmd  = bus.Ref_cmd;
                w_addr = bus.Ref_addr;
                w_ba   = bus.Ref_ba;
            end
            ST_WRITE: begin
                w_cmd  = bus.Wr_cmd;
                w_addr = bus.Wr_addr;
                w_ba   = bus.Wr_ba;
            end
            ST_READ: begin
                w_cmd  = bus.Rd_cmd;
                w_addr = bus.Rd_addr;
                w_ba   = bus.Rd_ba;
            end
            default: begin
                w_cmd  = CMD_NOP;
                w_addr = '0;
                w_ba   = '0;
            end
        endcase
        if (w_timeout) begin
            w_cmd  = CMD_NOP;
            w_addr = '0;
            w_ba   = '0;
        end
    end

    // ---------------- timer and alternation history ----------------
    always_ff @(posedge Sys_clk or posedge Rst) begin
        if (Rst) begin
            r_timer   <= '0;
            r_last_wr <= 1'b0;
        end else begin
            if (w_grant) begin
                r_timer <= '0;
            end else if (w_owner && (r_timer != c_timeout)) begin
                r_timer <= r_timer + 10'd1;
            end
            if (w_grant && (w_next == ST_WRITE)) r_last_wr <= 1'b1;
            else if (w_grant && (w_next == ST_READ)) r_last_wr <= 1'b0;
        end
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge Sys_clk or posedge Rst) begin
        if (Rst) begin
            r_ref_en      <= 1'b0;
            r_wr_en       <= 1'b0;
            r_rd_en       <= 1'b0;
            r_ref_pending <= 1'b0;
            r_arb_err     <= 1'b0;
            r_cmd         <= CMD_NOP;
            r_addr        <= '0;
            r_ba          <= '0;
        end else begin
            r_ref_en      <= w_grant && (w_next == ST_REFRESH);
            r_wr_en       <= w_grant && (w_next == ST_WRITE);
            r_rd_en       <= w_grant && (w_next == ST_READ);
            r_ref_pending <= bus.Ref_req && ((r_state == ST_WRITE) || (r_state == ST_READ));
            r_arb_err     <= w_timeout;
            r_cmd         <= w_cmd;
            r_addr        <= w_addr;
            r_ba          <= w_ba;
        end
    end

    assign bus.Ref_en          = r_ref_en;
    assign bus.Wr_en           = r_wr_en;
    assign bus.Rd_en           = r_rd_en;
    assign bus.Ref_pending     = r_ref_pending;
    assign bus.Arb_err         = r_arb_err;
    assign bus.SDRAM_CMD       = r_cmd;
    assign bus.SDRAM_A_ADDR    = r_addr;
    assign bus.SDRAM_BANK_ADDR = r_ba;

endmodule
`default_nettype wire

// File: tb/tb_sdram_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_cmd_arbiter
//  Description : Self-checking bench for the SDRAM command-bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_cmd_arbiter;

    localparam int c_timeout = 1023;

    localparam int SRC_NOP  = 0;
    localparam int SRC_INIT = 1;
    localparam int SRC_REF  = 2;
    localparam int SRC_WR   = 3;
    localparam int SRC_RD   = 4;

    typedef struct {
        logic id, rq, re, wq, we, dq, de;
        int   src;
        logic ren, wen, den, pend, err;
    } vec_t;

    logic Sys_clk;
    logic Rst;
    int   n_checks;
    int   n_fail;

    vec_t tv[$];
    vec_t sb[$];

    sdram_cmd_arbiter_if bus ();

    sdram_cmd_arbiter dut (
        .Sys_clk (Sys_clk),
        .Rst     (Rst),
        .bus     (bus)
    );

    initial Sys_clk = 1'b0;
    always #5 Sys_clk = ~Sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Sys_clk);
        #1;
    endtask

    function automatic vec_t mk(input logic id, rq, re, wq, we, dq, de, input int src,
                                input logic ren, wen, den, pend, err);
        vec_t v;
        v.id = id; v.rq = rq; v.re = re; v.wq = wq; v.we = we; v.dq = dq; v.de = de;
        v.src = src; v.ren = ren; v.wen = wen; v.den = den; v.pend = pend; v.err = err;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.Init_done = v.id;
        bus.Ref_req   = v.rq;
        bus.Ref_end   = v.re;
        bus.Wr_req    = v.wq;
        bus.Wr_end    = v.we;
        bus.Rd_req    = v.dq;
        bus.Rd_end    = v.de;
    endtask

    // Pin values expected for a given source; NOP only fixes the command
    task automatic check_pins(input string tag, input int src);
        logic [3:0]  ecmd;
        logic [11:0] eaddr;
        logic [1:0]  eba;
        case (src)
            SRC_INIT: begin ecmd = 4'b0010; eaddr = 12'h111; eba = 2'd0; end
            SRC_REF:  begin ecmd = 4'b0001; eaddr = 12'h222; eba = 2'd1; end
            SRC_WR:   begin ecmd = 4'b0100; eaddr = 12'h0A5; eba = 2'd2; end
            SRC_RD:   begin ecmd = 4'b0101; eaddr = 12'h3C3; eba = 2'd3; end
            default:  begin ecmd = 4'b0111; eaddr = 12'h000; eba = 2'd0; end
        endcase
        check({tag, ".cmd"}, 32'(bus.SDRAM_CMD), 32'(ecmd));
        if (src != SRC_NOP) begin
            check({tag, ".addr"}, 32'(bus.SDRAM_A_ADDR), 32'(eaddr));
            check({tag, ".ba"}, 32'(bus.SDRAM_BANK_ADDR), 32'(eba));
        end
    endtask

    task automatic check_flags(input string tag, input vec_t e);
        check({tag, ".Ref_en"},      32'(bus.Ref_en),      32'(e.ren));
        check({tag, ".Wr_en"},       32'(bus.Wr_en),       32'(e.wen));
        check({tag, ".Rd_en"},       32'(bus.Rd_en),       32'(e.den));
        check({tag, ".Ref_pending"}, 32'(bus.Ref_pending), 32'(e.pend));
        check({tag, ".Arb_err"},     32'(bus.Arb_err),     32'(e.err));
    endtask

    initial begin
        vec_t v;
        vec_t e;
        n_checks = 0;
        n_fail   = 0;

        bus.Init_cmd = 4'b0010; bus.Init_addr = 12'h111; bus.Init_ba = 2'd0;
        bus.Ref_cmd  = 4'b0001; bus.Ref_addr  = 12'h222; bus.Ref_ba  = 2'd1;
        bus.Wr_cmd   = 4'b0100; bus.Wr_addr   = 12'h0A5; bus.Wr_ba   = 2'd2;
        bus.Rd_cmd   = 4'b0101; bus.Rd_addr   = 12'h3C3; bus.Rd_ba   = 2'd3;
        v = mk(0,0,0,0,0,0,0, SRC_NOP, 0,0,0,0,0);
        drive(v);

        //        id rq re wq we dq de  src       ren wen den pnd err
        tv.push_back(mk(0,0,0,0,0,0,0, SRC_INIT, 0,0,0,0,0)); // init engine on pins
        tv.push_back(mk(1,0,0,0,0,0,0, SRC_INIT, 0,0,0,0,0)); // INIT -> IDLE
        tv.push_back(mk(1,0,0,1,0,0,0, SRC_NOP,  0,1,0,0,0)); // write grant
        tv.push_back(mk(1,0,0,1,0,0,0, SRC_WR,   0,0,0,0,0));
        tv.push_back(mk(1,0,0,0,1,0,0, SRC_WR,   0,0,0,0,0)); // Wr_end
        tv.push_back(mk(1,0,0,0,0,0,0, SRC_NOP,  0,0,0,0,0));
        tv.push_back(mk(1,0,0,0,0,1,0, SRC_NOP,  0,0,1,0,0)); // read grant
        tv.push_back(mk(1,0,0,0,0,1,0, SRC_RD,   0,0,0,0,0));
        tv.push_back(mk(1,0,0,0,0,0,1, SRC_RD,   0,0,0,0,0)); // Rd_end
        tv.push_back(mk(1,0,0,0,0,0,0, SRC_NOP,  0,0,0,0,0));
        tv.push_back(mk(1,1,0,1,0,1,0, SRC_NOP,  1,0,0,0,0)); // all three: refresh wins
        tv.push_back(mk(1,0,0,1,0,1,0, SRC_REF,  0,0,0,0,0));
        tv.push_back(mk(1,0,1,1,0,1,0, SRC_REF,  0,0,0,0,0)); // Ref_end
        tv.push_back(mk(1,0,0,1,0,1,0, SRC_NOP,  0,1,0,0,0)); // write first
        tv.push_back(mk(1,0,0,1,1,1,0, SRC_WR,   0,0,0,0,0));
        tv.push_back(mk(1,0,0,1,0,1,0, SRC_NOP,  0,0,1,0,0)); // then read
        tv.push_back(mk(1,0,0,1,0,1,1, SRC_RD,   0,0,0,0,0));
        tv.push_back(mk(1,0,0,1,0,1,0, SRC_NOP,  0,1,0,0,0)); // alternate back
        tv.push_back(mk(1,0,1,1,0,1,1, SRC_WR,   0,0,0,0,0)); // non-owner ends ignored
        tv.push_back(mk(1,1,0,1,0,1,0, SRC_WR,   0,0,0,1,0)); // refresh pending
        tv.push_back(mk(1,1,0,0,1,1,0, SRC_WR,   0,0,0,1,0)); // Wr_end with Ref_req
        tv.push_back(mk(1,1,0,0,0,1,0, SRC_NOP,  1,0,0,0,0)); // refresh beats read
        tv.push_back(mk(1,0,1,0,0,1,0, SRC_REF,  0,0,0,0,0));
        tv.push_back(mk(1,0,0,0,0,1,0, SRC_NOP,  0,0,1,0,0));
        tv.push_back(mk(0,0,0,0,0,0,0, SRC_RD,   0,0,0,0,0)); // Init_done drops in READ
        tv.push_back(mk(0,0,0,0,0,0,0, SRC_INIT, 0,0,0,0,0));
        tv.push_back(mk(1,0,0,0,0,0,0, SRC_INIT, 0,0,0,0,0));
        tv.push_back(mk(1,0,0,0,0,0,0, SRC_NOP,  0,0,0,0,0));

        // Reset values
        Rst = 1'b1;
        repeat (3) @(posedge Sys_clk);
        #1;
        check_pins("reset", SRC_NOP);
        check("reset.addr", 32'(bus.SDRAM_A_ADDR), 32'h0);
        check("reset.ba", 32'(bus.SDRAM_BANK_ADDR), 32'h0);
        check_flags("reset", v);
        Rst = 1'b0;
        check_pins("post_release", SRC_NOP);

        // Table vectors through the scoreboard: one cycle of pin latency
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i]);
            sb.push_back(tv[i]);
            step();
            e = sb.pop_front();
            check_pins($sformatf("vec%0d", i), e.src);
            check_flags($sformatf("vec%0d", i), e);
        end

        // Owner timeout: Wr_end never arrives
        v = mk(1,0,0,1,0,0,0, SRC_NOP, 0,1,0,0,0);
        drive(v);
        step();
        check_flags("to_grant", v);
        check_pins("to_grant", SRC_NOP);
        v = mk(1,0,0,0,0,0,0, SRC_WR, 0,0,0,0,0);
        drive(v);
        for (int k = 0; k < c_timeout; k++) begin
            step();
            if (bus.Arb_err !== 1'b0 || bus.SDRAM_CMD !== 4'b0100 || k == c_timeout - 1) begin
                check($sformatf("to_hold%0d.err", k), 32'(bus.Arb_err), 32'h0);
                check($sformatf("to_hold%0d.cmd", k), 32'(bus.SDRAM_CMD), 32'h4);
            end
        end
        step();
        check("to_fire.err", 32'(bus.Arb_err), 32'h1);
        check_pins("to_fire", SRC_NOP);
        step();
        check("to_after.err", 32'(bus.Arb_err), 32'h0);
        check_pins("to_after", SRC_NOP);

        // Asynchronous reset in the middle of a read burst
        v = mk(1,0,0,0,0,1,0, SRC_NOP, 0,0,1,0,0);
        drive(v);
        step();
        check_flags("rd_grant", v);
        v = mk(1,0,0,0,0,0,0, SRC_RD, 0,0,0,0,0);
        drive(v);
        step();
        check_pins("rd_burst", SRC_RD);
        #3;
        Rst = 1'b1;
        #1;
        check_pins("async_rst", SRC_NOP);
        check_flags("async_rst", mk(1,0,0,0,0,0,0, SRC_NOP, 0,0,0,0,0));
        repeat (2) @(posedge Sys_clk);
        #1;
        Rst = 1'b0;
        step();
        check_pins("reinit", SRC_INIT);
        step();
        check_pins("reinit_idle", SRC_NOP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
